// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared types and constants for the load/store access unit.
//   state_t : FSM state encoding (IDLE, READ, WRITE, RESP)
//   F3_*    : RV32I funct3 size/sign encodings for loads and stores
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// lane_align: combinational little-endian lane handling for the access unit.
//   word       in  32  word read from memory
//   wdata      in  32  store data (low byte / low halfword used for SB / SH)
//   addr_lo    in  2   byte offset within the word
//   funct3     in  3   RV32I size/sign encoding
//   is_write   in  1   1 = store, 0 = load
//   load_data  out 32  extracted and extended load value (0 if illegal)
//   store_word out 32  old word with the store lane merged in
//   err        out 1   misaligned access or illegal funct3
import mem_access_pkg::*;

module lane_align (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_write,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic        err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (addr_lo)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      default: lane_b = word[31:24];
    endcase
    lane_h = addr_lo[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, lane_b};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    store_word = word;
    case (funct3)
      F3_B: begin
        case (addr_lo)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

  // Stores have no unsigned forms, so anything from 011 upward is illegal.
  always_comb begin
    err = 1'b1;
    if (is_write) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = addr_lo[0];
        F3_W:    err = |addr_lo;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = addr_lo[0];
        F3_W:        err = |addr_lo;
        default:     err = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store access unit in front of a word-addressed data
// memory (async read, sync write). One request in flight; one response each.
//   clk, reset_n              clock, async active-low reset
//   req_valid/req_ready       request handshake (ready only in IDLE)
//   req_write, req_funct3     store/load select and RV32I size encoding
//   req_addr, req_wdata       byte address and store data
//   resp_valid/err/rdata      one-cycle response; err/rdata hold until next
//   mem_addr, mem_din         word-aligned address and write word
//   mem_read, mem_write       memory strobes (READ / WRITE state only)
//   mem_dout                  memory read data
import mem_access_pkg::*;

module mem_access_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);

  state_t      state;
  logic        lat_write;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic [31:0] lat_wdata;

  logic        al_write;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        al_err;

  // In IDLE the aligner checks the live request for errors; afterwards it
  // works on the latched request to extract or merge the read word.
  always_comb begin
    al_write   = lat_write;
    al_funct3  = lat_funct3;
    al_addr_lo = lat_addr_lo;
    if (state == IDLE) begin
      al_write   = req_write;
      al_funct3  = req_funct3;
      al_addr_lo = req_addr[1:0];
    end
  end

  lane_align u_lane_align (
    .word       (mem_dout),
    .wdata      (lat_wdata),
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .is_write   (al_write),
    .load_data  (load_data),
    .store_word (store_word),
    .err        (al_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lat_write   <= 1'b0;
      lat_funct3  <= 3'd0;
      lat_addr_lo <= 2'd0;
      lat_wdata   <= 32'd0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'd0;
      mem_addr    <= 32'd0;
      mem_din     <= 32'd0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write   <= req_write;
            lat_funct3  <= req_funct3;
            lat_addr_lo <= req_addr[1:0];
            lat_wdata   <= req_wdata;
            req_ready   <= 1'b0;
            if (al_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else if (req_write && (req_funct3 == F3_W)) begin
              // Full-word store needs no read-modify-write.
              state     <= WRITE;
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_din   <= req_wdata;
            end else begin
              state    <= READ;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[31:2], 2'b00};
            end
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (lat_write) begin
            state     <= WRITE;
            mem_write <= 1'b1;
            mem_din   <= store_word;
          end else begin
            state      <= RESP;
            mem_addr   <= 32'd0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WRITE: begin
          state      <= RESP;
          mem_write  <= 1'b0;
          mem_addr   <= 32'd0;
          mem_din    <= 32'd0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          mem_addr   <= 32'd0;
          mem_din    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_dout;

  int checks;
  int failures;

  logic [31:0] mem [0:1023];
  logic        bl_en;
  logic [9:0]  bl_idx;
  logic [31:0] bl_data;

  mem_access_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_dout = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_write)  mem[mem_addr[11:2]] <= mem_din;
    else if (bl_en) mem[bl_idx] <= bl_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] data);
    bl_en = 1'b1; bl_idx = idx; bl_data = data;
    @(posedge clk); #1;
    bl_en = 1'b0;
  endtask

  // Issues one request from IDLE and checks the full response profile.
  // Latency k counts sample points after E0 (k=1 is the cycle after E0).
  task automatic expect_txn(input string tag, input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                            input int e_nrd, input int e_nwr,
                            input logic [31:0] e_maddr, input logic [31:0] e_wdin);
    logic [31:0] rdata, maddr, wdin;
    logic        err, rdy_after;
    int          lat, nrd, nwr;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_funct3 = 3'b111;
    req_addr = 32'hFFFF_FFFF; req_wdata = ~wd;
    lat = -1; nrd = 0; nwr = 0; maddr = 32'd0; wdin = 32'd0;
    rdata = 32'hXXXX_XXXX; err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      if (mem_read)  begin nrd++; maddr = mem_addr; end
      if (mem_write) begin nwr++; maddr = mem_addr; wdin = mem_din; end
      if (resp_valid) begin lat = k; rdata = resp_rdata; err = resp_err; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_after = req_ready & ~resp_valid;
    chk({tag, "_lat"},   32'(lat),   32'(e_lat));
    chk({tag, "_rdata"}, rdata,      e_rdata);
    chk({tag, "_err"},   32'(err),   32'(e_err));
    chk({tag, "_nrd"},   32'(nrd),   32'(e_nrd));
    chk({tag, "_nwr"},   32'(nwr),   32'(e_nwr));
    chk({tag, "_maddr"}, maddr,      e_maddr);
    chk({tag, "_wdin"},  wdin,       e_wdin);
    chk({tag, "_idle"},  32'(rdy_after), 32'd1);
  endtask

  initial begin
    int first_rd, lw_lat;
    logic [31:0] lw_data;
    checks = 0; failures = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    bl_en = 1'b0; bl_idx = 10'd0; bl_data = 32'd0;

    #12;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_strobes", {28'd0, mem_read, mem_write, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset abort during the WRITE cycle of SW 0x100 <- 0xDEADBEEF.
    preload(10'd64, 32'h80FF_1234);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_wr_high", 32'(mem_write), 32'd1);
    chk("abort_wr_addr", mem_addr, 32'h100);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_wr_fall", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    chk("abort_mem", mem[64], 32'h80FF_1234);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_outs", {28'd0, mem_read, mem_write, resp_valid, resp_err}, 32'd0);
    chk("abort_data", resp_rdata | mem_addr | mem_din, 32'd0);

    // Loads from 0x100 = 0x80FF_1234.
    expect_txn("lw",  1'b0, 3'b010, 32'h100, 32'd0, 32'h80FF_1234, 1'b0, 2, 1, 0, 32'h100, 32'd0);
    expect_txn("lb",  1'b0, 3'b000, 32'h103, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h100, 32'd0);
    expect_txn("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 32'h0000_0080, 1'b0, 2, 1, 0, 32'h100, 32'd0);
    expect_txn("lh",  1'b0, 3'b001, 32'h102, 32'd0, 32'hFFFF_80FF, 1'b0, 2, 1, 0, 32'h100, 32'd0);

    // SB / SH read-modify-write over 0x1122_3344.
    preload(10'd64, 32'h1122_3344);
    expect_txn("sb", 1'b1, 3'b000, 32'h102, 32'h0000_00AB, 32'd0, 1'b0, 3, 1, 1, 32'h100, 32'h11AB_3344);
    chk("sb_mem", mem[64], 32'h11AB_3344);
    preload(10'd64, 32'h1122_3344);
    expect_txn("sh", 1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'd0, 1'b0, 3, 1, 1, 32'h100, 32'hBEEF_3344);
    chk("sh_mem", mem[64], 32'hBEEF_3344);
    expect_txn("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 32'h0000_BEEF, 1'b0, 2, 1, 0, 32'h100, 32'd0);

    // Errors: misaligned and illegal funct3, no strobes, response after E0.
    expect_txn("err_lw",  1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0);
    expect_txn("err_sh",  1'b1, 3'b001, 32'h103, 32'h5555_AAAA, 32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0);
    expect_txn("err_l3",  1'b0, 3'b011, 32'h100, 32'd0, 32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0);
    expect_txn("err_s4",  1'b1, 3'b100, 32'h100, 32'h1, 32'd0, 1'b1, 1, 0, 0, 32'd0, 32'd0);
    chk("err_mem", mem[64], 32'hBEEF_3344);

    // Back-to-back: SW then LW with req_valid held high throughout.
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_write = 1'b0; req_wdata = 32'd0;
    first_rd = -1; lw_lat = -1; lw_data = 32'd0;
    for (int k = 1; k <= 10; k++) begin
      if (mem_read && first_rd < 0) begin first_rd = k; req_valid = 1'b0; end
      if (resp_valid && k > 2) begin lw_lat = k; lw_data = resp_rdata; break; end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    chk("b2b_accept", 32'(first_rd), 32'd4);
    chk("b2b_lat", 32'(lw_lat), 32'd5);
    chk("b2b_data", lw_data, 32'hCAFE_F00D);
    chk("b2b_mem", mem[128], 32'hCAFE_F00D);
    @(posedge clk); #1;
    chk("b2b_idle", 32'(req_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
